sccb_write_master: RTL and testbench

//  Single-register SCCB (OV7670-style) 3-phase write master: ID byte, sub-address, data.

---
 rtl/sccb_write_master.sv | 189 ++++++++++++++++++
 tb/tb_sccb_write_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_write_master.sv
// SCCB (OV7670-style) single-register 3-phase write master: ID byte, sub-address, data.
// Define SCCB_ACK_CHECK_EN to sample the 9th bit of each phase and flag a NACK.
module sccb_write_master #(
    parameter int         QTR_DIV = 250,
    parameter logic [7:0] DEV_ID  = 8'h42
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] reg_data_i,
    input  logic       siod_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       nack_o,
    output logic       sioc_o,
    output logic       siod_o,
    output logic       siod_oe_o
);
    localparam int            QW   = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QTR_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [QW-1:0] r_qcnt, w_qcnt_nxt;
    logic [1:0]    r_step, w_step_nxt;
    logic [3:0]    r_bit, w_bit_nxt;
    logic [1:0]    r_phase, w_phase_nxt;
    logic [23:0]   r_shift, w_shift_nxt;
    logic          r_sioc, w_sioc_nxt;
    logic          r_siod, w_siod_nxt;
    logic          r_oe, w_oe_nxt;
    logic          r_nack, w_nack_nxt;
    logic          w_busy;
    logic          w_tick;

`ifndef SCCB_ACK_CHECK_EN
    logic w_unused_siod;
    assign w_unused_siod = siod_i;
`endif

    assign ready_o   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign done_o    = (r_state == S_DONE);
    assign nack_o    = r_nack;
    assign sioc_o    = r_sioc;
    assign siod_o    = r_siod;
    assign siod_oe_o = r_oe;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_qcnt  <= '0;
            r_step  <= 2'd0;
            r_bit   <= 4'd0;
            r_phase <= 2'd0;
            r_sioc  <= 1'b1;
            r_siod  <= 1'b1;
            r_oe    <= 1'b0;
            r_nack  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
            r_step  <= w_step_nxt;
            r_bit   <= w_bit_nxt;
            r_phase <= w_phase_nxt;
            r_sioc  <= w_sioc_nxt;
            r_siod  <= w_siod_nxt;
            r_oe    <= w_oe_nxt;
            r_nack  <= w_nack_nxt;
        end
    end

    // Frame shifter carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        r_shift <= w_shift_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_step_nxt  = r_step;
        w_bit_nxt   = r_bit;
        w_phase_nxt = r_phase;
        w_shift_nxt = r_shift;
        w_sioc_nxt  = r_sioc;
        w_siod_nxt  = r_siod;
        w_oe_nxt    = r_oe;
        w_nack_nxt  = r_nack;
        w_busy      = (r_state == S_START) || (r_state == S_BIT) || (r_state == S_STOP);
        w_tick      = w_busy && (r_qcnt == QMAX);

        if (w_busy) begin
            w_qcnt_nxt = w_tick ? '0 : r_qcnt + QW'(1);
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (start_i) begin
                    w_state_nxt = S_START;
                    w_qcnt_nxt  = '0;
                    w_step_nxt  = 2'd0;
                    w_bit_nxt   = 4'd0;
                    w_phase_nxt = 2'd0;
                    w_shift_nxt = {DEV_ID, reg_addr_i, reg_data_i};
                    w_nack_nxt  = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_step == 2'd0) begin
                        w_oe_nxt   = 1'b1;
                        w_siod_nxt = 1'b0;
                        w_step_nxt = 2'd1;
                    end else begin
                        w_sioc_nxt  = 1'b0;
                        w_step_nxt  = 2'd0;
                        w_state_nxt = S_BIT;
                    end
                end
            end
            S_BIT: begin
                if (w_tick) begin
                    w_step_nxt = r_step + 2'd1;
                    case (r_step)
                        2'd0: begin
                            // 9th bit of each phase is released to the pull-up.
                            if (r_bit == 4'd8) begin
                                w_oe_nxt   = 1'b0;
                                w_siod_nxt = 1'b1;
                            end else begin
                                w_oe_nxt   = 1'b1;
                                w_siod_nxt = r_shift[23];
                            end
                        end
                        2'd1: w_sioc_nxt = 1'b1;
                        2'd2: begin
`ifdef SCCB_ACK_CHECK_EN
                            if ((r_bit == 4'd8) && siod_i) begin
                                w_nack_nxt = 1'b1;
                            end
`endif
                        end
                        default: begin
                            w_sioc_nxt = 1'b0;
                            if (r_bit == 4'd8) begin
                                w_bit_nxt = 4'd0;
                                if (r_phase == 2'd2) begin
                                    w_state_nxt = S_STOP;
                                end else begin
                                    w_phase_nxt = r_phase + 2'd1;
                                end
                            end else begin
                                w_bit_nxt   = r_bit + 4'd1;
                                w_shift_nxt = {r_shift[22:0], 1'b0};
                            end
                        end
                    endcase
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_step_nxt = r_step + 2'd1;
                    case (r_step)
                        2'd0: begin
                            w_oe_nxt   = 1'b1;
                            w_siod_nxt = 1'b0;
                        end
                        2'd1: w_sioc_nxt = 1'b1;
                        default: begin
                            w_oe_nxt    = 1'b0;
                            w_siod_nxt  = 1'b1;
                            w_step_nxt  = 2'd0;
                            w_state_nxt = S_DONE;
                        end
                    endcase
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_sccb_write_master.sv
// Self-checking bench for sccb_write_master: tick-table reference model plus directed and random writes.
module tb_sccb_write_master;
    localparam int Q     = 4;
    localparam int TICKS = 113;
    localparam int LAT   = TICKS * Q + 1;
`ifdef SCCB_ACK_CHECK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic       siod_i = 1'b0;
    logic [7:0] reg_addr_i = 8'h00;
    logic [7:0] reg_data_i = 8'h00;
    logic       ready_o, done_o, nack_o, sioc_o, siod_o, siod_oe_o;

    int checks = 0;
    int failures = 0;

    sccb_write_master #(.QTR_DIV(Q), .DEV_ID(8'h42)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .siod_i(siod_i),
        .ready_o(ready_o), .done_o(done_o), .nack_o(nack_o),
        .sioc_o(sioc_o), .siod_o(siod_o), .siod_oe_o(siod_oe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Bus levels after tick k of a transaction carrying frame {ID, addr, data}.
    function automatic void tick_exp(input int k, input logic [23:0] fr,
                                     output logic sc, output logic oe, output logic sd);
        int j, b, q, pos, byt;
        sc = 1'b1; oe = 1'b0; sd = 1'b1;
        if (k == 0) begin sc = 1'b1; oe = 1'b1; sd = 1'b0; end
        else if (k == 1) begin sc = 1'b0; oe = 1'b1; sd = 1'b0; end
        else if (k < 110) begin
            j = k - 2; b = j / 4; q = j % 4; pos = b % 9; byt = b / 9;
            sc = (q == 1) || (q == 2);
            if (pos == 8) begin oe = 1'b0; sd = 1'b1; end
            else begin oe = 1'b1; sd = fr[23 - byt * 8 - pos]; end
        end
        else if (k == 110) begin sc = 1'b0; oe = 1'b1; sd = 1'b0; end
        else if (k == 111) begin sc = 1'b1; oe = 1'b1; sd = 1'b0; end
        else begin sc = 1'b1; oe = 1'b0; sd = 1'b1; end
    endfunction

    function automatic bit is_ack_tick(input int k);
        if (k < 2 || k >= 110) return 1'b0;
        return (((k - 2) % 4) == 2) && ((((k - 2) / 4) % 9) == 8);
    endfunction

    // Reference model: cycles since accept, latched frame, NACK flag.
    bit          m_active = 1'b0;
    int          m_n = 0;
    logic [23:0] m_frame = '0;
    logic        m_nack = 1'b0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_active = 1'b0; m_n = 0; m_nack = 1'b0;
        end else begin
            if ((!m_active || m_n == TICKS * Q) && start_i) begin
                m_active = 1'b1; m_n = 0; m_nack = 1'b0;
                m_frame = {8'h42, reg_addr_i, reg_data_i};
            end else if (m_active) begin
                if (m_n == TICKS * Q) m_active = 1'b0;
                else begin
                    m_n++;
                    if (ACK_EN && (m_n % Q == 0) && is_ack_tick(m_n / Q - 1) && siod_i)
                        m_nack = 1'b1;
                end
            end
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk_i) begin : cmp
        logic esc, eoe, esd;
        logic erdy, edone;
        if (cmp_en) begin
            if (!m_active || m_n < Q) begin esc = 1'b1; eoe = 1'b0; esd = 1'b1; end
            else tick_exp(m_n / Q - 1, m_frame, esc, eoe, esd);
            erdy  = !m_active || (m_n == TICKS * Q);
            edone = m_active && (m_n == TICKS * Q);
            check("sioc", sioc_o, esc);
            check("siod_oe", siod_oe_o, eoe);
            if (eoe) check("siod", siod_o, esd);
            check("ready", ready_o, erdy);
            check("done", done_o, edone);
            check("nack", nack_o, m_nack);
        end
    end

    // Pad level seen by the slave on every SIOC rising edge.
    logic prev_sioc = 1'b1;
    logic cap_q[$];
    always @(negedge clk_i) begin
        if (sioc_o === 1'b1 && prev_sioc === 1'b0) cap_q.push_back(siod_oe_o ? siod_o : 1'b1);
        prev_sioc = sioc_o;
    end

    bit rnd_en = 1'b0;
    always @(negedge clk_i) begin
        if (rnd_en) begin #1; siod_i = ($urandom_range(0, 7) == 0); end
    end

    task automatic check_capture(input string tag, input logic [7:0] a, input logic [7:0] d);
        logic [23:0] expf;
        logic [7:0]  byt;
        expf = {8'h42, a, d};
        check($sformatf("%s_nbits", tag), cap_q.size(), 28);
        if (cap_q.size() >= 27) begin
            for (int p = 0; p < 3; p++) begin
                for (int b = 0; b < 8; b++) byt[7 - b] = cap_q[p * 9 + b];
                check($sformatf("%s_byte%0d", tag, p), byt, expf[23 - 8 * p -: 8]);
                check($sformatf("%s_ackbit%0d", tag, p), cap_q[p * 9 + 8], 1'b1);
            end
        end
    endtask

    task automatic start_txn(input logic [7:0] a, input logic [7:0] d);
        #1;
        reg_addr_i = a; reg_data_i = d; start_i = 1'b1;
    endtask

    task automatic wait_done(input bit drop, input bit junk, input bit ackw, output int lat);
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
            if (lat == 1) cap_q.delete();
            if (drop && lat == 1) begin #1; start_i = 1'b0; end
            if (junk && lat == 10) begin #1; start_i = 1'b1; reg_addr_i = 8'hFF; reg_data_i = 8'h00; end
            if (junk && lat == 11) begin #1; start_i = 1'b0; end
            if (ackw && lat == 285) begin #1; siod_i = 1'b1; end
            if (ackw && lat == 296) begin #1; siod_i = 1'b0; end
        end while (done_o !== 1'b1 && lat < 600);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] ra, rd;
        #2 rst_i = 1'b1;
        #2;
        check("t1_rst_sioc", sioc_o, 1'b1);
        check("t1_rst_oe", siod_oe_o, 1'b0);
        check("t1_rst_ready", ready_o, 1'b1);
        check("t1_rst_done", done_o, 1'b0);
        check("t1_rst_nack", nack_o, 1'b0);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("t1_rel_sioc", sioc_o, 1'b1);
        check("t1_rel_oe", siod_oe_o, 1'b0);
        check("t1_rel_ready", ready_o, 1'b1);
        check("t1_rel_done", done_o, 1'b0);

        start_txn(8'h12, 8'h80);
        wait_done(1'b1, 1'b0, 1'b0, lat);
        check("t2_latency", lat, 453);
        check_capture("t2", 8'h12, 8'h80);
        @(negedge clk_i);
        check("t2_done_pulse", done_o, 1'b0);

        start_txn(8'h5A, 8'hC3);
        wait_done(1'b1, 1'b1, 1'b0, lat);
        check("t3_latency", lat, LAT);
        check_capture("t3", 8'h5A, 8'hC3);
        @(negedge clk_i);

        start_txn(8'h33, 8'h44);
        @(negedge clk_i);
        #1 start_i = 1'b0;
        repeat (320) @(negedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        check("t4_sioc", sioc_o, 1'b1);
        check("t4_oe", siod_oe_o, 1'b0);
        check("t4_ready", ready_o, 1'b1);
        check("t4_done", done_o, 1'b0);
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        start_txn(8'hA5, 8'h5A);
        wait_done(1'b1, 1'b0, 1'b0, lat);
        check("t4_latency", lat, LAT);
        check_capture("t4", 8'hA5, 8'h5A);
        @(negedge clk_i);

        start_txn(8'h01, 8'hFE);
        wait_done(1'b0, 1'b0, 1'b0, lat);
        check("t5a_latency", lat, LAT);
        check_capture("t5a", 8'h01, 8'hFE);
        #1 reg_addr_i = 8'hC0; reg_data_i = 8'h3F;
        wait_done(1'b1, 1'b0, 1'b0, lat);
        check("t5b_latency", lat, LAT);
        check_capture("t5b", 8'hC0, 8'h3F);
        @(negedge clk_i);

        start_txn(8'h11, 8'h22);
        wait_done(1'b1, 1'b0, 1'b1, lat);
        check("t6_latency", lat, LAT);
        check("t6_nack_end", nack_o, ACK_EN);
        @(negedge clk_i);
        check("t6_nack_held", nack_o, ACK_EN);
        start_txn(8'h77, 8'h88);
        wait_done(1'b1, 1'b0, 1'b0, lat);
        check("t6_nack_cleared", nack_o, 1'b0);
        @(negedge clk_i);

        rnd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom);
            rd = 8'($urandom);
            start_txn(ra, rd);
            wait_done(1'b1, ($urandom_range(0, 1) == 1), 1'b0, lat);
            check($sformatf("rnd%0d_latency", i), lat, LAT);
            check_capture($sformatf("rnd%0d", i), ra, rd);
            repeat ($urandom_range(1, 5)) @(negedge clk_i);
        end
        rnd_en = 1'b0;
        @(negedge clk_i);
        #1 siod_i = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
